// File: rtl/thread_pool_dispatcher.sv
// Job dispatcher: buffers jobs in a FIFO, issues them round-robin to idle worker
// threads, and returns tagged results on a single valid/ready stream.
module thread_pool_dispatcher #(
  parameter int NUM_THREADS = 4,
  parameter int JOB_W       = 32,
  parameter int RES_W       = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [JOB_W-1:0]               job_data,
  output logic [NUM_THREADS-1:0]         thr_start,
  output logic [JOB_W-1:0]               thr_job,
  input  logic [NUM_THREADS-1:0]         thr_done,
  input  logic [NUM_THREADS*RES_W-1:0]   thr_result,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [RES_W-1:0]               res_data,
  output logic [TID_W-1:0]               res_tid,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           err_done_unexp
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } thr_state_e;

  // Thread index arithmetic that wraps at NUM_THREADS (not necessarily a power of two).
  function automatic logic [TID_W-1:0] wrap_add(input logic [TID_W-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= NUM_THREADS) sum = sum - NUM_THREADS;
    return TID_W'(sum);
  endfunction

  // Returns {found, index} of the first set mask bit at or after ptr, wrapping.
  function automatic logic [TID_W:0] rr_pick(input logic [NUM_THREADS-1:0] mask,
                                             input logic [TID_W-1:0] ptr);
    logic [TID_W:0]   res;
    logic [TID_W-1:0] cand;
    res = '0;
    for (int k = 0; k < NUM_THREADS; k++) begin
      cand = wrap_add(ptr, k);
      if (!res[TID_W] && mask[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- job FIFO
  logic [JOB_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;

  assign job_ready  = (count_reg != CNT_W'(FIFO_DEPTH));
  assign push       = job_valid && job_ready;
  assign fifo_count = count_reg;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= job_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------- thread states
  logic [NUM_THREADS-1:0] idle_mask;
  logic [NUM_THREADS-1:0] run_mask;
  logic [NUM_THREADS-1:0] hold_mask;
  logic [RES_W-1:0]       result_arr [NUM_THREADS];
  logic                   dispatch_en;
  logic [TID_W-1:0]       disp_idx;
  logic                   accept;
  logic [TID_W-1:0]       res_tid_reg;

  for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thr
    thr_state_e state_reg;
    thr_state_e state_next;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
    end

    always_comb begin
      state_next = state_reg;
      unique case (state_reg)
        ST_IDLE: if (dispatch_en && disp_idx == TID_W'(gi)) state_next = ST_RUN;
        ST_RUN:  if (thr_done[gi]) state_next = ST_HOLD;
        ST_HOLD: if (accept && res_tid_reg == TID_W'(gi)) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end

    assign idle_mask[gi]  = (state_reg == ST_IDLE);
    assign run_mask[gi]   = (state_reg == ST_RUN);
    assign hold_mask[gi]  = (state_reg == ST_HOLD);
    assign result_arr[gi] = thr_result[gi*RES_W +: RES_W];
  end

  // ---------------------------------------------------------------- dispatch
  logic [TID_W-1:0]       disp_ptr_reg;
  logic [NUM_THREADS-1:0] thr_start_reg;
  logic [JOB_W-1:0]       thr_job_reg;
  logic                   disp_found;

  always_comb begin
    {disp_found, disp_idx} = rr_pick(idle_mask, disp_ptr_reg);
  end

  // A job pushed into an empty FIFO is not bypassed; it dispatches next cycle.
  assign dispatch_en = disp_found && (count_reg != '0);
  assign pop         = dispatch_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_start_reg <= '0;
      thr_job_reg   <= '0;
      disp_ptr_reg  <= '0;
    end else begin
      thr_start_reg <= '0;
      if (dispatch_en) begin
        thr_start_reg[disp_idx] <= 1'b1;
        thr_job_reg             <= fifo_mem[rd_ptr_reg];
        disp_ptr_reg            <= wrap_add(disp_idx, 1);
      end
    end
  end

  assign thr_start = thr_start_reg;
  assign thr_job   = thr_job_reg;

  // --------------------------------------------------------- result capture
  logic [NUM_THREADS-1:0] done_ok;
  logic [RES_W-1:0]       slot_mem [NUM_THREADS];
  logic                   err_reg;

  assign done_ok = thr_done & run_mask;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (done_ok[i]) slot_mem[i] <= result_arr[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_reg <= 1'b0;
    else if (|(thr_done & ~run_mask)) err_reg <= 1'b1;
  end

  assign err_done_unexp = err_reg;

  // ----------------------------------------------------------- result output
  logic                   res_valid_reg;
  logic [RES_W-1:0]       res_data_reg;
  logic [TID_W-1:0]       out_ptr_reg;
  logic [NUM_THREADS-1:0] presented;
  logic [NUM_THREADS-1:0] out_cand;
  logic                   out_found;
  logic [TID_W-1:0]       out_idx;
  logic [RES_W-1:0]       out_data;
  logic                   load_en;

  always_comb begin
    presented = '0;
    if (res_valid_reg) presented[res_tid_reg] = 1'b1;
  end

  // Fresh completions compete directly so a done pulse shows up one cycle later.
  assign out_cand = (hold_mask & ~presented) | done_ok;
  assign load_en  = !res_valid_reg || res_ready;
  assign accept   = res_valid_reg && res_ready;

  always_comb begin
    {out_found, out_idx} = rr_pick(out_cand, out_ptr_reg);
    out_data = hold_mask[out_idx] ? slot_mem[out_idx] : result_arr[out_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_tid_reg   <= '0;
      out_ptr_reg   <= '0;
    end else if (load_en) begin
      res_valid_reg <= out_found;
      if (out_found) begin
        res_data_reg <= out_data;
        res_tid_reg  <= out_idx;
        out_ptr_reg  <= wrap_add(out_idx, 1);
      end
    end
  end

  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_tid   = res_tid_reg;

endmodule

// File: tb/tb_thread_pool_dispatcher.sv
// Self-checking bench for thread_pool_dispatcher: directed scenarios plus a
// randomized run checked against an array/queue model of the dispatch rules.
module tb_thread_pool_dispatcher;

  localparam int NT = 4;
  localparam int JW = 32;
  localparam int RW = 32;
  localparam int FD = 8;
  localparam int TW = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic             clk;
  logic             rst_n;
  logic             job_valid;
  logic             job_ready;
  logic [JW-1:0]    job_data;
  logic [NT-1:0]    thr_start;
  logic [JW-1:0]    thr_job;
  logic [NT-1:0]    thr_done;
  logic [NT*RW-1:0] thr_result;
  logic             res_valid;
  logic             res_ready;
  logic [RW-1:0]    res_data;
  logic [TW-1:0]    res_tid;
  logic [3:0]       fifo_count;
  logic             err_done_unexp;

  int n_checks = 0;
  int n_fail   = 0;

  thread_pool_dispatcher #(
    .NUM_THREADS(NT), .JOB_W(JW), .RES_W(RW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
    .thr_start(thr_start), .thr_job(thr_job),
    .thr_done(thr_done), .thr_result(thr_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tid(res_tid),
    .fifo_count(fifo_count), .err_done_unexp(err_done_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; job_valid = 1'b0; job_data = '0;
    thr_done = '0; thr_result = '0; res_ready = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic push_jobs(input logic [JW-1:0] base, input int n, input int idle_after);
    for (int c = 0; c < n + idle_after; c++) begin
      job_valid = (c < n);
      job_data  = base + JW'(c);
      tick;
    end
    job_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    n_checks++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
    n_checks++; if (thr_start !== 4'b0) begin n_fail++; $display("FAIL reset_thr_start: got %b want 0000", thr_start); end
    n_checks++; if (thr_job !== 32'h0) begin n_fail++; $display("FAIL reset_thr_job: got %h want 0", thr_job); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL reset_res_data: got %h want 0", res_data); end
    n_checks++; if (res_tid !== 2'd0) begin n_fail++; $display("FAIL reset_res_tid: got %0d want 0", res_tid); end
    n_checks++; if (err_done_unexp !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_done_unexp); end
  endtask

  task automatic test_dispatch_order;
    int peak;
    logic [NT-1:0] exp_start;
    do_reset;
    peak = 0;
    for (int c = 0; c < 7; c++) begin
      job_valid = (c < 4);
      job_data  = 32'hA0 + JW'(c);
      tick;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      exp_start = (c >= 1 && c <= 4) ? NT'(1 << (c - 1)) : '0;
      n_checks++; if (thr_start !== exp_start) begin n_fail++; $display("FAIL order_start c=%0d: got %b want %b", c, thr_start, exp_start); end
      if (c >= 1 && c <= 4) begin
        n_checks++; if (thr_job !== 32'hA0 + JW'(c - 1)) begin n_fail++; $display("FAIL order_job c=%0d: got %h want %h", c, thr_job, 32'hA0 + c - 1); end
      end
    end
    job_valid = 1'b0;
    n_checks++; if (peak !== 1) begin n_fail++; $display("FAIL order_peak_count: got %0d want 1", peak); end
  endtask

  task automatic test_fifo_full;
    int accepted;
    bit will;
    do_reset;
    accepted = 0;
    job_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      job_data = 32'hB00 + JW'(accepted);
      will = job_ready;
      tick;
      if (will) accepted++;
    end
    n_checks++; if (accepted !== 12) begin n_fail++; $display("FAIL full_accepted: got %0d want 12", accepted); end
    n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL full_count: got %0d want 8", fifo_count); end
    n_checks++; if (job_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", job_ready); end
    job_data = 32'hB00 + JW'(accepted);
    thr_done = 4'b0001; thr_result[0 +: RW] = 32'hD0; res_ready = 1'b1;
    tick;
    thr_done = '0;
    n_checks++; if (res_valid !== 1'b1 || res_tid !== 2'd0 || res_data !== 32'hD0) begin n_fail++; $display("FAIL full_result: got v=%b t=%0d d=%h want v=1 t=0 d=d0", res_valid, res_tid, res_data); end
    tick;
    tick;
    n_checks++; if (thr_start !== 4'b0001 || thr_job !== 32'hB04) begin n_fail++; $display("FAIL full_redispatch: got %b/%h want 0001/b04", thr_start, thr_job); end
    n_checks++; if (fifo_count !== 4'd7 || job_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop: got cnt=%0d rdy=%b want 7/1", fifo_count, job_ready); end
    tick;
    n_checks++; if (fifo_count !== 4'd8 || job_ready !== 1'b0) begin n_fail++; $display("FAIL full_refill: got cnt=%0d rdy=%b want 8/0", fifo_count, job_ready); end
    job_valid = 1'b0;
    res_ready = 1'b0;
  endtask

  task automatic test_simul_done;
    do_reset;
    push_jobs(32'hC0, 4, 3);
    thr_done = 4'b1010;
    thr_result = '0;
    thr_result[1*RW +: RW] = 32'h11;
    thr_result[3*RW +: RW] = 32'h33;
    res_ready = 1'b1;
    tick;
    thr_done = '0;
    n_checks++; if (res_valid !== 1'b1 || res_tid !== 2'd1 || res_data !== 32'h11) begin n_fail++; $display("FAIL simul_first: got v=%b t=%0d d=%h want 1/1/11", res_valid, res_tid, res_data); end
    tick;
    n_checks++; if (res_valid !== 1'b1 || res_tid !== 2'd3 || res_data !== 32'h33) begin n_fail++; $display("FAIL simul_second: got v=%b t=%0d d=%h want 1/3/33", res_valid, res_tid, res_data); end
    tick;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL simul_drained: got %b want 0", res_valid); end
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    do_reset;
    push_jobs(32'hE0, 5, 3);
    res_ready = 1'b0;
    thr_done = 4'b0100;
    thr_result[2*RW +: RW] = 32'h22;
    tick;
    thr_done = '0;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (res_valid !== 1'b1 || res_tid !== 2'd2 || res_data !== 32'h22) begin n_fail++; $display("FAIL bp_stable k=%0d: got v=%b t=%0d d=%h want 1/2/22", k, res_valid, res_tid, res_data); end
      n_checks++; if (thr_start !== 4'b0 || fifo_count !== 4'd1) begin n_fail++; $display("FAIL bp_no_dispatch k=%0d: got %b cnt=%0d want 0000/1", k, thr_start, fifo_count); end
      tick;
    end
    res_ready = 1'b1;
    tick;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_accepted: got %b want 0", res_valid); end
    tick;
    n_checks++; if (thr_start !== 4'b0100 || thr_job !== 32'hE4 || fifo_count !== 4'd0) begin n_fail++; $display("FAIL bp_redispatch: got %b/%h cnt=%0d want 0100/e4/0", thr_start, thr_job, fifo_count); end
    res_ready = 1'b0;
  endtask

  task automatic test_err_unexpected;
    do_reset;
    thr_done = 4'b0100;
    thr_result[2*RW +: RW] = 32'hBAD;
    tick;
    thr_done = '0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (err_done_unexp !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL err_sticky k=%0d: got err=%b v=%b want 1/0", k, err_done_unexp, res_valid); end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    push_jobs(32'hF0, 4, 3);
    res_ready = 1'b0;
    thr_done = 4'b0001;
    thr_result[0 +: RW] = 32'h55;
    tick;
    thr_done = '0;
    push_jobs(32'hF4, 2, 1);
    n_checks++; if (fifo_count !== 4'd2 || res_valid !== 1'b1) begin n_fail++; $display("FAIL mid_setup: got cnt=%0d v=%b want 2/1", fifo_count, res_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (fifo_count !== 4'd0 || job_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async_fifo: got cnt=%0d rdy=%b want 0/1", fifo_count, job_ready); end
    n_checks++; if (res_valid !== 1'b0 || res_data !== 32'h0 || res_tid !== 2'd0) begin n_fail++; $display("FAIL mid_async_res: got v=%b d=%h t=%0d want 0/0/0", res_valid, res_data, res_tid); end
    n_checks++; if (thr_job !== 32'h0 || thr_start !== 4'b0) begin n_fail++; $display("FAIL mid_async_thr: got %h/%b want 0/0000", thr_job, thr_start); end
    tick;
    rst_n = 1'b1;
    tick;
    n_checks++; if (fifo_count !== 4'd0 || thr_start !== 4'b0) begin n_fail++; $display("FAIL mid_after_release: got cnt=%0d st=%b want 0/0000", fifo_count, thr_start); end
    thr_done = 4'b0010;
    tick;
    thr_done = '0;
    n_checks++; if (err_done_unexp !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_done: got err=%b v=%b want 1/0", err_done_unexp, res_valid); end
  endtask

  task automatic test_random;
    logic [JW-1:0] q[$];
    int            ts[NT];
    int            rem[NT];
    logic [RW-1:0] hres[NT];
    int            dptr, optr, m_tid, e_tid, sidx, oidx, idx;
    logic          m_rv, e_rv, push, acc, load;
    logic [RW-1:0] m_data, e_data;
    logic [NT-1:0] e_start;
    do_reset;
    for (int i = 0; i < NT; i++) begin ts[i] = M_IDLE; rem[i] = 0; hres[i] = '0; end
    dptr = 0; optr = 0; m_rv = 1'b0; m_tid = 0; m_data = '0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      job_valid = (cyc < 440) && ($urandom_range(0, 2) != 0);
      job_data  = $urandom;
      res_ready = ($urandom_range(0, 3) != 0);
      thr_done  = '0;
      for (int i = 0; i < NT; i++) begin
        if (ts[i] == M_RUN) begin
          if (rem[i] == 0) begin thr_done[i] = 1'b1; thr_result[i*RW +: RW] = $urandom; end
          else rem[i]--;
        end
      end
      // expected behaviour at the coming edge, from the model's pre-edge state
      push = job_valid && (q.size() < FD);
      sidx = -1;
      if (q.size() > 0)
        for (int k = 0; k < NT; k++) begin
          idx = (dptr + k) % NT;
          if (sidx < 0 && ts[idx] == M_IDLE) sidx = idx;
        end
      acc = m_rv && res_ready;
      load = !m_rv || res_ready;
      e_rv = m_rv; e_tid = m_tid; e_data = m_data; oidx = -1;
      if (load) begin
        for (int k = 0; k < NT; k++) begin
          idx = (optr + k) % NT;
          if (oidx < 0 && ((ts[idx] == M_HOLD && !(m_rv && m_tid == idx)) || (thr_done[idx] && ts[idx] == M_RUN))) oidx = idx;
        end
        e_rv = (oidx >= 0);
        if (oidx >= 0) begin
          e_tid = oidx;
          e_data = (ts[oidx] == M_HOLD) ? hres[oidx] : thr_result[oidx*RW +: RW];
        end
      end
      e_start = (sidx >= 0) ? NT'(1 << sidx) : '0;
      tick;
      n_checks++; if (thr_start !== e_start) begin n_fail++; $display("FAIL rand_start cyc=%0d: got %b want %b", cyc, thr_start, e_start); end
      if (sidx >= 0) begin
        n_checks++; if (thr_job !== q[0]) begin n_fail++; $display("FAIL rand_job cyc=%0d: got %h want %h", cyc, thr_job, q[0]); end
      end
      n_checks++; if (res_valid !== e_rv) begin n_fail++; $display("FAIL rand_res_valid cyc=%0d: got %b want %b", cyc, res_valid, e_rv); end
      if (e_rv) begin
        n_checks++; if (res_tid !== TW'(e_tid) || res_data !== e_data) begin n_fail++; $display("FAIL rand_res cyc=%0d: got t=%0d d=%h want t=%0d d=%h", cyc, res_tid, res_data, e_tid, e_data); end
      end
      // advance the model
      if (acc) begin
        ts[m_tid] = M_IDLE;
        $display("txn cyc=%0d result tid=%0d data=%h", cyc, m_tid, m_data);
      end
      for (int i = 0; i < NT; i++)
        if (thr_done[i] && ts[i] == M_RUN) begin ts[i] = M_HOLD; hres[i] = thr_result[i*RW +: RW]; end
      if (sidx >= 0) begin
        ts[sidx] = M_RUN; rem[sidx] = $urandom_range(0, 5);
        void'(q.pop_front());
        dptr = (sidx + 1) % NT;
      end
      if (push) q.push_back(job_data);
      if (load) begin
        m_rv = e_rv; m_tid = e_tid; m_data = e_data;
        if (oidx >= 0) optr = (oidx + 1) % NT;
      end
      n_checks++; if (fifo_count !== 4'(q.size()) || job_ready !== (q.size() < FD)) begin n_fail++; $display("FAIL rand_fifo cyc=%0d: got cnt=%0d rdy=%b want %0d", cyc, fifo_count, job_ready, q.size()); end
      n_checks++; if (err_done_unexp !== 1'b0) begin n_fail++; $display("FAIL rand_err cyc=%0d: got %b want 0", cyc, err_done_unexp); end
    end
    job_valid = 1'b0;
    res_ready = 1'b0;
    thr_done  = '0;
  endtask

  initial begin
    rst_n = 1'b0; job_valid = 1'b0; job_data = '0;
    thr_done = '0; thr_result = '0; res_ready = 1'b0;
    test_reset;
    test_dispatch_order;
    test_fifo_full;
    test_simul_done;
    test_backpressure;
    test_err_unexpected;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
